// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per clock with frame strobes.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a word; d_ready high, serial outputs quiet
//   SHIFT | WIDTH cycles of frame bits; reload allowed on the last bit when
//         | no gap is configured
//   GAP   | GAP_CYCLES quiet cycles after a frame; d_ready low
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         d_in,
  input  logic                     d_valid,
  output logic                     d_ready,
  output logic                     s_out,
  output logic                     s_valid,
  output logic                     s_last,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT_IDX = CW'(WIDTH - 2);
  localparam logic [7:0]    GAP_LOAD   = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  sreg, sreg_nxt;
  logic [7:0]        gap_cnt, gap_cnt_nxt;
  logic              s_out_nxt, s_valid_nxt, s_last_nxt, done_nxt;
  logic [CW-1:0]     bit_cnt_nxt;
  logic              last_bit;
  logic              ready_dec;
  logic              xfer;

  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // sreg always holds the bits still to be sent, aligned so the next one is at the lead end
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign last_bit = (state == SHIFT) && (bit_cnt == LAST_IDX);

  always_comb begin
    ready_dec = 1'b0;
    case (state)
      IDLE:    ready_dec = 1'b1;
      SHIFT:   ready_dec = last_bit && (GAP_CYCLES == 0);
      default: ready_dec = 1'b0;
    endcase
  end

  // held low for the whole reset window, not just after the registers clear
  assign d_ready = reset && ready_dec;
  assign xfer    = d_valid && d_ready;

  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg;
    gap_cnt_nxt = gap_cnt;
    s_out_nxt   = 1'b0;
    s_valid_nxt = 1'b0;
    s_last_nxt  = 1'b0;
    bit_cnt_nxt = '0;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (xfer) begin
          state_nxt   = SHIFT;
          sreg_nxt    = advance(d_in);
          s_out_nxt   = lead_bit(d_in);
          s_valid_nxt = 1'b1;
        end
      end

      SHIFT: begin
        if (!last_bit) begin
          sreg_nxt    = advance(sreg);
          s_out_nxt   = lead_bit(sreg);
          s_valid_nxt = 1'b1;
          bit_cnt_nxt = bit_cnt + CW'(1);
          s_last_nxt  = (bit_cnt == PENULT_IDX);
        end else begin
          done_nxt = 1'b1;
          if (xfer) begin
            sreg_nxt    = advance(d_in);
            s_out_nxt   = lead_bit(d_in);
            s_valid_nxt = 1'b1;
          end else if (GAP_CYCLES > 0) begin
            state_nxt   = GAP;
            gap_cnt_nxt = GAP_LOAD;
            sreg_nxt    = '0;
          end else begin
            state_nxt = IDLE;
            sreg_nxt  = '0;
          end
        end
      end

      GAP: begin
        if (gap_cnt == 8'd0) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - 8'd1;
        end
      end

      default: begin
        state_nxt   = IDLE;
        sreg_nxt    = '0;
        gap_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sreg    <= '0;
      gap_cnt <= 8'd0;
      s_out   <= 1'b0;
      s_valid <= 1'b0;
      s_last  <= 1'b0;
      bit_cnt <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      gap_cnt <= gap_cnt_nxt;
      s_out   <= s_out_nxt;
      s_valid <= s_valid_nxt;
      s_last  <= s_last_nxt;
      bit_cnt <= bit_cnt_nxt;
      done    <= done_nxt;
    end
  end

endmodule
